serial_rx_align: RTL and testbench

//  Receive side of the PHY serial link: deserialises the MSB-first bit stream produced by
//  the lane serialiser, finds byte alignment on the idle comma (8'hBC), and presents bytes.

---
 rtl/phy_pkg.sv | 18 +
 rtl/serial_rx_align_if.sv | 35 +++
 rtl/rx_shift8.sv | 40 ++++
 rtl/serial_rx_align.sv | 148 ++++++++++++++
 tb/tb_serial_rx_align.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/phy_pkg.sv
// ----------------------------------------------------------------------------
// phy_pkg
// Shared definitions for the PHY serial link: the idle/alignment comma and the
// receive-aligner state type. Also used by the serialiser and lane checkers.
// ----------------------------------------------------------------------------
package phy_pkg;

    // Idle byte sent by the transmitter whenever it has no valid data
    localparam logic [7:0] COMMA_BYTE = 8'hBC;

    // Receive aligner states (2-bit encoding)
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_rx_align_if.sv
// ----------------------------------------------------------------------------
// serial_rx_align_if
// Bundle between the serial lane and the receive aligner.
//   serial_in : serial bit, MSB of each byte first
//   data_out  : last received byte
//   valid_out : data_out carries a data byte (not comma/idle)
//   byte_stb  : one-cycle pulse when data_out/valid_out update
//   locked    : aligner is in the LOCKED state
// master = lane/consumer side, slave = the aligner.
// ----------------------------------------------------------------------------
interface serial_rx_align_if;

    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_stb;
    logic       locked;

    modport master (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  byte_stb,
        input  locked
    );

    modport slave (
        input  serial_in,
        output data_out,
        output valid_out,
        output byte_stb,
        output locked
    );

endinterface

// File: rtl/rx_shift8.sv
// ----------------------------------------------------------------------------
// rx_shift8
// 8-bit MSB-first shift register with comma compare.
//   clk_i      : bit clock
//   rst_n_i    : synchronous active-low reset
//   bit_i      : incoming serial bit
//   sr_next_o  : value the register takes on this edge (newest bit at LSB)
//   is_comma_o : sr_next_o equals COMMA
// ----------------------------------------------------------------------------
module rx_shift8 #(
    parameter logic [7:0] COMMA = 8'hBC
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       bit_i,
    output logic [7:0] sr_next_o,
    output logic       is_comma_o
);

    logic [7:0] sr_q;
    logic [7:0] sr_d;

    // Next shift value: older bits move toward MSB, new bit enters at LSB
    always_comb begin
        sr_d = {sr_q[6:0], bit_i};
    end

    // Shift register storage
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sr_q <= 8'h00;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_next_o  = sr_d;
    assign is_comma_o = (sr_d == COMMA);

endmodule

// File: rtl/serial_rx_align.sv
// ----------------------------------------------------------------------------
// serial_rx_align
// Receive side of the PHY serial link. Deserialises the MSB-first stream,
// aligns on BC_LOCK_COUNT consecutive commas and then presents one byte per
// 8 bit-clocks. Commas are delivered with valid_out=0. Lock is held until reset.
//   clk_8f  : bit clock
//   reset_L : synchronous active-low reset
//   lane    : serial_in in; data_out, valid_out, byte_stb, locked out
// ----------------------------------------------------------------------------
module serial_rx_align
    import phy_pkg::*;
#(
    parameter logic [7:0]  COMMA         = COMMA_BYTE,
    parameter int unsigned BC_LOCK_COUNT = 4
) (
    input  logic              clk_8f,
    input  logic              reset_L,
    serial_rx_align_if.slave  lane
);

    localparam logic [1:0] ST_HUNT   = HUNT;
    localparam logic [1:0] ST_ALIGN  = ALIGN;
    localparam logic [1:0] ST_LOCKED = LOCKED;
    localparam logic [3:0] LOCK_CNT  = 4'(BC_LOCK_COUNT);

    logic [7:0] sr_next_s;
    logic       is_comma_s;
    logic       boundary_s;
    logic [3:0] bc_inc_s;

    logic [1:0] state_q,   state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q,  bc_cnt_d;
    logic [7:0] data_q,    data_d;
    logic       valid_q,   valid_d;
    logic       stb_q,     stb_d;
    logic       locked_q,  locked_d;

    rx_shift8 #(.COMMA(COMMA)) u_shift (
        .clk_i      (clk_8f),
        .rst_n_i    (reset_L),
        .bit_i      (lane.serial_in),
        .sr_next_o  (sr_next_s),
        .is_comma_o (is_comma_s)
    );

    assign boundary_s = (bit_cnt_q == 3'd7);
    // Saturating comma count
    assign bc_inc_s   = (bc_cnt_q < LOCK_CNT) ? (bc_cnt_q + 4'd1) : bc_cnt_q;

    // Aligner FSM, counters and output next-state
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        stb_d     = 1'b0;
        locked_d  = locked_q;
        case (state_q)
            ST_HUNT: begin
                // Comma at any bit offset fixes the byte boundary at this edge
                if (is_comma_s) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 4'd1;
                    if (LOCK_CNT == 4'd1) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        data_d   = COMMA;
                        valid_d  = 1'b0;
                        stb_d    = 1'b1;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary_s) begin
                    if (is_comma_s) begin
                        bc_cnt_d = bc_inc_s;
                        // Lock-entry edge also delivers the final comma
                        if (bc_inc_s == LOCK_CNT) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            data_d   = COMMA;
                            valid_d  = 1'b0;
                            stb_d    = 1'b1;
                        end else begin
                            state_d = ST_ALIGN;
                        end
                    end else begin
                        state_d  = ST_HUNT;
                        bc_cnt_d = 4'd0;
                    end
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_LOCKED: begin
                // Only boundary-aligned bytes are examined; straddling commas are ignored
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary_s) begin
                    data_d  = sr_next_s;
                    valid_d = !is_comma_s;
                    stb_d   = 1'b1;
                end else begin
                    stb_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_HUNT;
                bc_cnt_d = 4'd0;
                locked_d = 1'b0;
                valid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            state_q   <= ST_HUNT;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
            locked_q  <= locked_d;
        end
    end

    assign lane.data_out  = data_q;
    assign lane.valid_out = valid_q;
    assign lane.byte_stb  = stb_q;
    assign lane.locked    = locked_q;

endmodule

// File: tb/tb_serial_rx_align.sv
// ----------------------------------------------------------------------------
// tb_serial_rx_align
// Drives one serial stream into two aligners (lock count 4 and lock count 1).
// A reference model over the received bit window predicts each byte strobe;
// a negedge monitor pops and compares whenever the DUTs present outputs.
// ----------------------------------------------------------------------------
module tb_serial_rx_align;
    import phy_pkg::*;

    typedef struct {
        int         edge_no;
        logic [7:0] data;
        logic       valid;
    } ev_t;

    logic clk_8f    = 1'b0;
    logic reset_L   = 1'b0;
    logic serial_in = 1'b0;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // reference model state per instance (0: lock after 4, 1: lock after 1)
    logic [7:0] win = 8'h00;          // last 8 bits received since reset
    int lockn [2] = '{4, 1};
    int mode  [2] = '{0, 0};          // 0 hunting, 1 counting commas, 2 locked
    int nxt   [2] = '{0, 0};          // edge at which the next aligned byte completes
    int commas[2] = '{0, 0};
    ev_t q0[$];
    ev_t q1[$];

    always #5 clk_8f = ~clk_8f;

    serial_rx_align_if if4 ();
    serial_rx_align_if if1 ();
    assign if4.serial_in = serial_in;
    assign if1.serial_in = serial_in;

    serial_rx_align #(.COMMA(COMMA_BYTE), .BC_LOCK_COUNT(4)) dut4 (
        .clk_8f (clk_8f), .reset_L (reset_L), .lane (if4));
    serial_rx_align #(.COMMA(COMMA_BYTE), .BC_LOCK_COUNT(1)) dut1 (
        .clk_8f (clk_8f), .reset_L (reset_L), .lane (if1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void push(input int k, input ev_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void model_reset();
        win = 8'h00;
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; nxt[k] = 0; commas[k] = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Byte-level view: hunt for a comma window, then judge every 8th window
    function automatic void model_step(input int k);
        ev_t e;
        e.edge_no = edge_n;
        e.data    = win;
        e.valid   = (win != COMMA_BYTE);
        case (mode[k])
            0: if (win == COMMA_BYTE) begin
                commas[k] = 1;
                nxt[k]    = edge_n + 8;
                if (commas[k] >= lockn[k]) begin mode[k] = 2; push(k, e); end
                else mode[k] = 1;
            end
            1: if (edge_n == nxt[k]) begin
                if (win == COMMA_BYTE) begin
                    commas[k] = commas[k] + 1;
                    nxt[k]    = nxt[k] + 8;
                    if (commas[k] >= lockn[k]) begin mode[k] = 2; push(k, e); end
                end else begin
                    mode[k] = 0;
                end
            end
            2: if (edge_n == nxt[k]) begin
                push(k, e);
                nxt[k] = nxt[k] + 8;
            end
            default: mode[k] = 0;
        endcase
    endfunction

    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk_8f);
        edge_n++;
        win = {win[6:0], b};
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_idle(input string tag, input int k);
        if (k == 0) begin
            chk({tag, "_locked4"}, {31'd0, if4.locked}, 32'd0);
            chk({tag, "_valid4"},  {31'd0, if4.valid_out}, 32'd0);
            chk({tag, "_stb4"},    {31'd0, if4.byte_stb}, 32'd0);
        end else begin
            chk({tag, "_locked1"}, {31'd0, if1.locked}, 32'd0);
            chk({tag, "_valid1"},  {31'd0, if1.valid_out}, 32'd0);
            chk({tag, "_stb1"},    {31'd0, if1.byte_stb}, 32'd0);
        end
    endtask

    task automatic do_reset(input int n);
        reset_L = 1'b0;
        repeat (n) begin
            serial_in = 1'($urandom_range(0, 1));
            @(posedge clk_8f);
            edge_n++;
        end
        model_reset();
        #1;
        check_idle("reset", 0);
        check_idle("reset", 1);
        chk("reset_data4", {24'd0, if4.data_out}, 32'd0);
        chk("reset_data1", {24'd0, if1.data_out}, 32'd0);
        reset_L = 1'b1;
    endtask

    // Monitor: compare strobes/bytes against the scoreboard and lock status every cycle
    task automatic mon(input int k, input logic stb, input logic [7:0] d,
                       input logic v, input logic lk);
        ev_t e;
        logic have;
        logic exp_stb;
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (k == 0) ? q0.pop_front() : q1.pop_front();
        exp_stb = have && (e.edge_no == edge_n);
        chk($sformatf("u%0d_byte_stb", k), {31'd0, stb}, {31'd0, exp_stb});
        if (exp_stb && stb) begin
            chk($sformatf("u%0d_data_out", k), {24'd0, d}, {24'd0, e.data});
            chk($sformatf("u%0d_valid_out", k), {31'd0, v}, {31'd0, e.valid});
        end
        chk($sformatf("u%0d_locked", k), {31'd0, lk}, {31'd0, (mode[k] == 2)});
        if (!lk) chk($sformatf("u%0d_valid_unlocked", k), {31'd0, v}, 32'd0);
    endtask

    always @(negedge clk_8f) begin
        if (reset_L) begin
            mon(0, if4.byte_stb, if4.data_out, if4.valid_out, if4.locked);
            mon(1, if1.byte_stb, if1.data_out, if1.valid_out, if1.locked);
        end
    end

    initial begin
        logic [7:0] b;
        int r;

        // 1: reset with random bits
        do_reset(10);

        // 2: 3 junk bits then 4 commas
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) begin
            send_byte(COMMA_BYTE);
            chk("lock_early", {31'd0, if4.locked}, 32'd0);
        end
        send_byte(COMMA_BYTE);
        chk("lock_4th_locked", {31'd0, if4.locked}, 32'd1);
        chk("lock_4th_stb",    {31'd0, if4.byte_stb}, 32'd1);
        chk("lock_4th_data",   {24'd0, if4.data_out}, 32'h0000_00BC);
        chk("lock_4th_valid",  {31'd0, if4.valid_out}, 32'd0);
        chk("lock1_locked",    {31'd0, if1.locked}, 32'd1);

        // 3: data after lock
        send_byte(8'h5A);
        chk("data_5A", {23'd0, if4.valid_out, if4.data_out}, 32'h0000_015A);
        send_byte(8'hC3);
        chk("data_C3", {23'd0, if4.valid_out, if4.data_out}, 32'h0000_01C3);
        send_byte(COMMA_BYTE);
        chk("data_BC", {23'd0, if4.valid_out, if4.data_out}, 32'h0000_00BC);
        for (int i = 0; i < 24; i++) send_byte(8'($urandom));

        // 5: comma pattern straddling two data bytes
        send_byte(8'h0B);
        chk("false_0B", {23'd0, if4.valid_out, if4.data_out}, 32'h0000_010B);
        send_byte(8'hC0);
        chk("false_C0", {23'd0, if4.valid_out, if4.data_out}, 32'h0000_01C0);
        send_byte(8'h3C);

        // 6: reset mid-byte while locked, then relock
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        do_reset(1);
        for (int i = 0; i < 4; i++) send_byte(COMMA_BYTE);
        chk("relock_locked", {31'd0, if4.locked}, 32'd1);
        send_byte(8'hA5);
        chk("relock_A5", {23'd0, if4.valid_out, if4.data_out}, 32'h0000_01A5);

        // 4: broken alignment
        do_reset(3);
        send_byte(COMMA_BYTE);
        send_byte(COMMA_BYTE);
        send_byte(8'h00);
        chk("broken_abort", {31'd0, if4.locked}, 32'd0);
        for (int i = 0; i < 3; i++) send_byte(COMMA_BYTE);
        chk("broken_3rd", {31'd0, if4.locked}, 32'd0);
        send_byte(COMMA_BYTE);
        chk("broken_relock", {31'd0, if4.locked}, 32'd1);

        // random mix of commas, data and bit slips from fresh reset
        do_reset(2);
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       send_byte(COMMA_BYTE);
            else if (r == 4) send_bit(1'($urandom_range(0, 1)));
            else begin
                b = 8'($urandom);
                send_byte(b);
            end
        end

        @(negedge clk_8f);
        #1;
        chk("queue0_drained", q0.size(), 32'd0);
        chk("queue1_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
